// File: rtl/upsampler_variable.sv
// -----------------------------------------------------------------------------
// upsampler_variable
//
// Runtime-programmable integer-rate upsampler. Each accepted input sample is
// expanded into R output samples. The first output is the sample itself. The
// remaining R-1 outputs are all-zero words when HOLD_MODE=0, which is
// zero-stuffing for CIC interpolator integrators. They are copies of the
// sample when HOLD_MODE=1, which is sample-and-hold. A rate word of 0 is
// treated as 1.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   s_axis_in_*         input sample stream (tdata/tvalid/tready)
//   s_axis_rate_*       rate word R (tdata/tvalid). A load also flushes the
//                       datapath.
//   m_axis_out_*        output sample stream (tdata/tvalid registered, tready in)
// -----------------------------------------------------------------------------
module upsampler_variable #(
  parameter int DATA_WIDTH_INP  = 8,
  parameter int DATA_WIDTH_RATE = 16,
  parameter bit HOLD_MODE       = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_WIDTH_INP-1:0]  s_axis_in_tdata,
  input  logic                       s_axis_in_tvalid,
  output logic                       s_axis_in_tready,
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
  input  logic                       s_axis_rate_tvalid,
  output logic [DATA_WIDTH_INP-1:0]  m_axis_out_tdata,
  output logic                       m_axis_out_tvalid,
  input  logic                       m_axis_out_tready
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [DATA_WIDTH_RATE-1:0] rate_q, rate_d;
  logic [DATA_WIDTH_RATE-1:0] phase_q, phase_d;
  logic [DATA_WIDTH_INP-1:0]  held_q, held_d;
  logic [DATA_WIDTH_INP-1:0]  out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;

  logic [DATA_WIDTH_RATE-1:0] r_eff;
  logic                       last;
  logic                       in_xfer;
  logic                       out_xfer;

  assign r_eff    = (rate_q == '0) ? DATA_WIDTH_RATE'(1) : rate_q;
  assign last     = (phase_q == r_eff - DATA_WIDTH_RATE'(1));
  assign in_xfer  = s_axis_in_tvalid & s_axis_in_tready;
  assign out_xfer = out_valid_q & m_axis_out_tready;

  // A new sample can be taken when idle, or when the last phase of the current
  // sample leaves this cycle. This gives back-to-back samples with no bubble.
  // The ready output is gated with reset_n so that it is low for the whole
  // time reset is held, not only after the first clock edge.
  assign s_axis_in_tready = reset_n & ~s_axis_rate_tvalid &
                            ((state_q == IDLE) |
                             ((state_q == EMIT) & last & m_axis_out_tready));

  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tvalid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    phase_d     = phase_q;
    held_d      = held_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (s_axis_rate_tvalid) begin
      // A rate load flushes everything. An output handshake in the same cycle
      // is ignored, so the pending sample is lost.
      rate_d      = s_axis_rate_tdata;
      state_d     = IDLE;
      phase_d     = '0;
      held_d      = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else if (in_xfer) begin
      // in_xfer can only occur in IDLE or on the last phase of EMIT.
      state_d     = EMIT;
      phase_d     = '0;
      held_d      = s_axis_in_tdata;
      out_data_d  = s_axis_in_tdata;
      out_valid_d = 1'b1;
    end else if ((state_q == EMIT) && out_xfer) begin
      if (!last) begin
        phase_d    = phase_q + DATA_WIDTH_RATE'(1);
        out_data_d = HOLD_MODE ? held_q : '0;
      end else begin
        state_d     = IDLE;
        phase_d     = '0;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rate_q      <= DATA_WIDTH_RATE'(1);
      phase_q     <= '0;
      held_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      phase_q     <= phase_d;
      held_q      <= held_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_upsampler_variable.sv
// -----------------------------------------------------------------------------
// Testbench for upsampler_variable.
//
// A zero-stuffing instance and a sample-and-hold instance share the same
// stimulus. The predictor turns every accepted sample into R expected output
// slots. The monitor pops one slot on each output handshake and checks data,
// valid and ready against the queue contents.
// -----------------------------------------------------------------------------
module tb_upsampler_variable;

  localparam int DW = 8;
  localparam int RW = 16;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready_zs, in_ready_hd;
  logic [RW-1:0] rate_data;
  logic          rate_valid;
  logic [DW-1:0] out_data_zs, out_data_hd;
  logic          out_valid_zs, out_valid_hd;
  logic          out_ready;

  upsampler_variable #(.DATA_WIDTH_INP(DW), .DATA_WIDTH_RATE(RW), .HOLD_MODE(1'b0)) u_zs (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_in_tdata    (in_data),
    .s_axis_in_tvalid   (in_valid),
    .s_axis_in_tready   (in_ready_zs),
    .s_axis_rate_tdata  (rate_data),
    .s_axis_rate_tvalid (rate_valid),
    .m_axis_out_tdata   (out_data_zs),
    .m_axis_out_tvalid  (out_valid_zs),
    .m_axis_out_tready  (out_ready)
  );

  upsampler_variable #(.DATA_WIDTH_INP(DW), .DATA_WIDTH_RATE(RW), .HOLD_MODE(1'b1)) u_hd (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_in_tdata    (in_data),
    .s_axis_in_tvalid   (in_valid),
    .s_axis_in_tready   (in_ready_hd),
    .s_axis_rate_tdata  (rate_data),
    .s_axis_rate_tvalid (rate_valid),
    .m_axis_out_tdata   (out_data_hd),
    .m_axis_out_tvalid  (out_valid_hd),
    .m_axis_out_tready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Scoreboard queue with one entry per expected output slot.
  logic [DW-1:0] q_data[$];
  bit            q_first[$];
  int unsigned   model_rate = 1;

  function automatic void chk(string name, int act, int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // Monitor. It runs on the falling edge, before the predictor updates the
  // queue in this cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid_zs", int'(out_valid_zs), 0);
      chk("rst_data_zs",  int'(out_data_zs),  0);
      chk("rst_ready_zs", int'(in_ready_zs),  0);
      chk("rst_valid_hd", int'(out_valid_hd), 0);
      chk("rst_ready_hd", int'(in_ready_hd),  0);
    end else begin
      bit exp_v;
      bit exp_r;
      exp_v = (q_data.size() > 0);
      // Input is accepted when nothing is pending, or when only the final slot
      // remains and it leaves this cycle. A rate load always blocks input.
      exp_r = !rate_valid && ((q_data.size() == 0) ||
                              (q_data.size() == 1 && out_ready));
      chk("valid_zs", int'(out_valid_zs), int'(exp_v));
      chk("valid_hd", int'(out_valid_hd), int'(exp_v));
      chk("ready_zs", int'(in_ready_zs),  int'(exp_r));
      chk("ready_hd", int'(in_ready_hd),  int'(exp_r));
      if (exp_v && out_valid_zs) begin
        chk("data_zs", int'(out_data_zs), q_first[0] ? int'(q_data[0]) : 0);
        chk("data_hd", int'(out_data_hd), int'(q_data[0]));
        if (out_ready && !rate_valid) begin
          void'(q_data.pop_front());
          void'(q_first.pop_front());
        end
      end
    end
  end

  // Predictor. It records accepted samples and rate loads after the monitor
  // has run for this cycle.
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      q_data.delete();
      q_first.delete();
      model_rate = 1;
    end else if (rate_valid) begin
      q_data.delete();
      q_first.delete();
      model_rate = int'(rate_data);
    end else if (in_valid && in_ready_zs) begin
      int unsigned r;
      r = (model_rate == 0) ? 1 : model_rate;
      for (int i = 0; i < int'(r); i++) begin
        q_data.push_back(in_data);
        q_first.push_back(i == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rate(input int r);
    rate_data  = RW'(r);
    rate_valid = 1'b1;
    tick();
    rate_valid = 1'b0;
  endtask

  task automatic rand_cycles(input int n, input int ready_pct);
    for (int i = 0; i < n; i++) begin
      out_ready = ($urandom_range(99) < ready_pct);
      in_valid  = ($urandom_range(2) != 0);
      in_data   = DW'($urandom);
      if ($urandom_range(39) == 0) begin
        int pick;
        pick       = int'($urandom_range(6));
        rate_data  = RW'(pick);
        rate_valid = 1'b1;
      end else begin
        rate_valid = 1'b0;
      end
      tick();
    end
    rate_valid = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    rate_data  = '0;
    rate_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Bursts at rate 1 and rate 0 with valid held high. These must run with
    // no bubbles.
    load_rate(1);
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    load_rate(0);
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Rate 4 with 5 and -6 offered continuously, then rate 3.
    load_rate(4);
    in_valid = 1'b1;
    in_data  = 8'd5;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) in_data = 8'hFA;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    load_rate(3);
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) in_data = 8'd9;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();

    // Rate 4 with output ready toggling 1,0,0,1 to exercise stalls.
    load_rate(4);
    in_valid = 1'b1;
    in_data  = 8'd33;
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 == 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();

    // Rate load in the middle of an emission, followed by sample 8 at rate 2.
    load_rate(4);
    in_valid = 1'b1;
    in_data  = 8'd5;
    tick();
    in_valid = 1'b0;
    tick();
    load_rate(2);
    in_valid = 1'b1;
    in_data  = 8'd8;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    rand_cycles(400, 75);

    // Asynchronous reset asserted in the middle of an emission.
    load_rate(4);
    in_valid = 1'b1;
    in_data  = 8'd77;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'd3;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    rand_cycles(400, 90);

    // Drain the remaining expected slots, with a bounded wait.
    in_valid   = 1'b0;
    rate_valid = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 200 && q_data.size() != 0; i++) tick();
    repeat (2) tick();
    chk("drain_left", q_data.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
